sseg_p2s: RTL

Parallel-to-serial shifter for the 8-digit seven-segment display. Takes the 64-bit segment pattern produced by the segment-mapping stage and shifts it, MSB first, into the board's external chain of serial-in shift registers. Generates the serial clock, data, clear and output-enable lines, and reports busy/done to the display controller.

---
 rtl/sseg_p2s_if.sv | 24 ++
 rtl/sseg_p2s.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/sseg_p2s_if.sv
// Connection bundle between the display controller / segment-mapping stage
// and the serial shifter that drives the external shift-register chain.
interface sseg_p2s_if #(
  parameter int DATA_BITS = 64
);
  logic                 start;
  logic [DATA_BITS-1:0] par_data;
  logic                 busy;
  logic                 done;
  logic                 s_clk;
  logic                 s_data;
  logic                 s_clrn;
  logic                 s_pen;

  modport master (
    output start, par_data,
    input  busy, done, s_clk, s_data, s_clrn, s_pen
  );

  modport slave (
    input  start, par_data,
    output busy, done, s_clk, s_data, s_clrn, s_pen
  );
endinterface

// File: rtl/sseg_p2s.sv
// Parallel-to-serial shifter for the 8-digit seven-segment display chain.
// Shifts the 64-bit pattern out MSB first with a divided serial clock.
module sseg_p2s #(
  parameter int DATA_BITS = 64,
  parameter int CLK_DIV   = 2
) (
  input logic       clk,
  input logic       rst,
  sseg_p2s_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    LATCH    = 2'd3
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [5:0] BIT_LAST = 6'(DATA_BITS - 1);

  state_t               state_r;
  state_t               state_s;
  logic [7:0]           div_r;
  logic [7:0]           div_s;
  logic [5:0]           bit_r;
  logic [5:0]           bit_s;
  logic [DATA_BITS-1:0] shreg_r;
  logic [DATA_BITS-1:0] shreg_s;
  logic                 div_end_s;

  logic busy_r;
  logic done_r;
  logic s_clk_r;
  logic s_data_r;
  logic s_clrn_r;
  logic s_pen_r;
  logic busy_s;
  logic done_s;
  logic s_clk_s;
  logic s_data_s;
  logic s_pen_s;

  assign div_end_s = (div_r == DIV_LAST);

  // Next-state, counters and next values of the registered outputs.
  always_comb begin
    state_s = state_r;
    div_s   = div_r;
    bit_s   = bit_r;
    shreg_s = shreg_r;
    s_pen_s = s_pen_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          state_s = SHIFT_LO;
          shreg_s = bus.par_data;
          bit_s   = 6'd0;
          div_s   = 8'd0;
          s_pen_s = 1'b0;
        end else begin
          div_s = 8'd0;
        end
      end
      SHIFT_LO: begin
        if (div_end_s) begin
          state_s = SHIFT_HI;
          div_s   = 8'd0;
        end else begin
          div_s = div_r + 8'd1;
        end
      end
      SHIFT_HI: begin
        if (div_end_s) begin
          div_s = 8'd0;
          if (bit_r == BIT_LAST) begin
            state_s = LATCH;
          end else begin
            // Advance only at the end of the high phase so data moves on s_clk fall.
            shreg_s = {shreg_r[DATA_BITS-2:0], 1'b0};
            bit_s   = bit_r + 6'd1;
            state_s = SHIFT_LO;
          end
        end else begin
          div_s = div_r + 8'd1;
        end
      end
      LATCH: begin
        if (div_end_s) begin
          state_s = IDLE;
          div_s   = 8'd0;
          s_pen_s = 1'b1;
        end else begin
          div_s = div_r + 8'd1;
        end
      end
      default: begin
        state_s = IDLE;
        div_s   = 8'd0;
      end
    endcase

    busy_s  = (state_s != IDLE);
    done_s  = (state_r == LATCH) && (state_s == IDLE);
    s_clk_s = (state_s == SHIFT_HI);
    if ((state_s == SHIFT_LO) || (state_s == SHIFT_HI)) begin
      s_data_s = shreg_s[DATA_BITS-1];
    end else begin
      s_data_s = 1'b0;
    end
  end

  // State, counters, shift register and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      div_r    <= 8'd0;
      bit_r    <= 6'd0;
      shreg_r  <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      s_clk_r  <= 1'b0;
      s_data_r <= 1'b0;
      s_clrn_r <= 1'b0;
      s_pen_r  <= 1'b0;
    end else begin
      state_r  <= state_s;
      div_r    <= div_s;
      bit_r    <= bit_s;
      shreg_r  <= shreg_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
      s_clk_r  <= s_clk_s;
      s_data_r <= s_data_s;
      s_clrn_r <= 1'b1;
      s_pen_r  <= s_pen_s;
    end
  end

  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
  assign bus.s_clk  = s_clk_r;
  assign bus.s_data = s_data_r;
  assign bus.s_clrn = s_clrn_r;
  assign bus.s_pen  = s_pen_r;

endmodule
